// File: rtl/mips_dmem_ctrl.sv
// mips_dmem_ctrl: req/ack data-memory controller for the mips32 core.
// It supports big-endian byte, halfword and word lanes, signed or unsigned
// load extension, and misalignment checks. An access is latched in IDLE,
// waits WAIT_STATES cycles, and then completes in a single ACCESS cycle.
module mips_dmem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        load_uns,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [3:0] WS_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam int         DEPTH    = 2 ** ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  err_c;
  logic [31:0]           word;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_val;
  logic [3:0]            be;
  logic [31:0]           wword;

  // Upper address bits are dropped here, so the RAM wraps modulo its depth.
  assign idx  = addr_q[ADDR_WIDTH+1:2];
  assign off  = addr_q[1:0];
  assign word = mem[idx];

  // Reject the reserved size and any access that is not naturally aligned.
  always_comb begin
    err_c = 1'b0;
    case (size_q)
      2'b00:   err_c = 1'b0;
      2'b01:   err_c = off[0];
      2'b10:   err_c = (off != 2'b00);
      default: err_c = 1'b1;
    endcase
  end

  // Big-endian lane extraction, followed by right-justify and extend.
  always_comb begin
    lane_b   = 8'h00;
    lane_h   = off[1] ? word[15:0] : word[31:16];
    load_val = word;
    case (off)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = word;
    endcase
  end

  // Store data is replicated across all lanes; the byte enables pick the lanes that are written.
  always_comb begin
    be    = 4'b1111;
    wword = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b1000 >> off;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b0011 : 4'b1100;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  // Control FSM: latch the request in IDLE, count wait states, and retire in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr[ADDR_WIDTH+1:0];
          size_d  = size;
          uns_d   = load_uns;
          wdata_d = wdata;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == WS_LAST) state_d = S_ACCESS;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (err_c)      rdata_d = 32'h0;
        else if (!we_q) rdata_d = load_val;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rdata shows the fresh result during the ack cycle and holds it afterwards.
  assign rdata = rdata_d;
  assign ack   = (state_q == S_ACCESS);
  assign err   = ack & err_c;
  assign busy  = (state_q != S_IDLE);

  // Controller state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The store commits only on the edge that ends ACCESS, so a reset before that edge leaves the RAM untouched.
  always_ff @(posedge clock) begin
    if (reset && state_q == S_ACCESS && we_q && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule
